// File: rtl/pe_obuf_axis_pkg.sv
// Shared constants for the PE-row output buffer: FSM encodings and default word width.
package pe_obuf_axis_pkg;
  localparam int unsigned TBITS_DEF = 64;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/pe_obuf_axis_if.sv
// Valid/ready output stream from the PE-row output buffer toward the output DMA.
interface pe_obuf_axis_if
  import pe_obuf_axis_pkg::*;
#(
  parameter int unsigned TBITS = TBITS_DEF
);
  logic [TBITS-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic             m_last;

  modport master (output m_data, output m_valid, output m_last, input m_ready);
  modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/pe_sync_fifo.sv
// First-word-fall-through synchronous FIFO; the caller guarantees push/pop legality.
module pe_sync_fifo #(
  parameter int unsigned TBITS = 64,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [TBITS-1:0] wdata,
  output logic [TBITS-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);
  logic [TBITS-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is left unreset; only pointers and level define visible content.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (level_q == (AW+1)'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
endmodule

// File: rtl/pe_obuf_axis.sv
// PE-row output buffer: absorbs unstallable packer words, replays them as a framed
// valid/ready stream with LAST on the final word of each tile and a done pulse.
module pe_obuf_axis
  import pe_obuf_axis_pkg::*;
#(
  parameter int unsigned TBITS = TBITS_DEF,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned CNTW  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNTW-1:0]  cfg_words,
  input  logic [TBITS-1:0] data64_din,
  input  logic             valid64_din,
  pe_obuf_axis_if.master   m,
  output logic             busy,
  output logic             done,
  output logic             ovf_err,
  output logic [AW:0]      level
);
  logic [1:0]       state_q, state_d;
  logic [CNTW-1:0]  cfg_q, cfg_d;
  logic [CNTW-1:0]  out_cnt_q, out_cnt_d;
  logic             ovf_q, ovf_d;

  logic             push, pop, drop, start_ok;
  logic             full, empty, valid_o, last_o;
  logic [TBITS-1:0] rdata;

  assign start_ok = start & (state_q == ST_IDLE);
  assign valid_o  = ~empty & (state_q == ST_RUN);
  assign pop      = valid_o & m.m_ready;
  assign push     = valid64_din & (state_q != ST_IDLE) & (~full | pop);
  assign drop     = valid64_din & ~push;
  assign last_o   = valid_o & (out_cnt_q == cfg_q - 1'b1);

  always_comb begin
    state_d   = state_q;
    cfg_d     = cfg_q;
    out_cnt_d = out_cnt_q;
    ovf_d     = ovf_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (pop && last_o) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
    if (start_ok) begin
      cfg_d     = (cfg_words == '0) ? CNTW'(1) : cfg_words;
      out_cnt_d = '0;
      ovf_d     = 1'b0;
    end else if (pop) begin
      out_cnt_d = out_cnt_q + 1'b1;
    end
    // A loss in the same cycle as start still gets reported.
    if (drop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cfg_q     <= '0;
      out_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_q     <= cfg_d;
      out_cnt_q <= out_cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  pe_sync_fifo #(
    .TBITS (TBITS),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (data64_din),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign m.m_valid = valid_o;
  assign m.m_data  = valid_o ? rdata : '0;
  assign m.m_last  = last_o;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign ovf_err   = ovf_q;
endmodule
